router_input_port: RTL and testbench
====================================

# router_input_port

Per-port ingress stage of the mesh router, placed directly upstream of the per-output round-robin arbiters. It buffers incoming AXI-Stream flits in a small FIFO and computes the XY route from each packet's header flit. It holds that route for the whole packet and presents flits on exactly one of `REN` output request lanes, each lane feeding the arbiter of the selected output.

## Interface
- `DATA_W`, 32: flit width (tdata).
- `COORD_W`, 4: width of one mesh coordinate; requires `2*COORD_W <= DATA_W`.
- `X_COORD`, 0: this router's X coordinate.
- `Y_COORD`, 0: this router's Y coordinate.
- `FIFO_DEPTH`, 4: ingress buffer depth in flits; power of two, >= 2.
- `REN`, 5: number of output lanes; fixed order 0 local, 1 north, 2 east, 3 south, 4 west.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `s_tdata`  in  DATA_W  incoming flit.
- `s_tvalid`  in  1  incoming flit valid.
- `s_tlast`  in  1  last flit of packet.
- `s_tready`  out  1  ingress ready (= FIFO not full, 0 while `rst`).
- `m_tdata`  out  DATA_W  FIFO head flit, shared by all lanes.
- `m_tlast`  out  1  FIFO head tlast, shared.
- `m_tvalid`  out  REN  per-lane valid; at most one bit set (one-hot or zero).
- `m_tready`  in  REN  per-lane ready from the output arbiters.

## Operation
- Header flit = first flit of a packet. Destination X = `tdata[COORD_W-1:0]`, destination Y = `tdata[2*COORD_W-1:COORD_W]`, both unsigned. The header is forwarded unchanged as a normal flit.
- XY routing, X first:
  - dX > X_COORD → east (2); dX < X_COORD → west (4).
  - Otherwise dY > Y_COORD → north (1); dY < Y_COORD → south (3).
  - Otherwise → local (0).
- FIFO: push on `s_tvalid & s_tready`, pop on `m_tvalid[route_q] & m_tready[route_q]`.
  - Simultaneous push and pop are legal when the FIFO is not full; the count is unchanged.
  - There is no push when full, even if a pop occurs in the same cycle (`s_tready` is strictly `!full`).
  - Pointers wrap modulo `FIFO_DEPTH`; the count is `$clog2(FIFO_DEPTH)+1` bits wide.
- FSM, 2 states:
  - HEAD, the reset state. All `m_tvalid` are 0. If the FIFO is non-empty, latch `route_q` from the head flit and go to BODY; nothing is popped in HEAD.
  - BODY. `m_tvalid[route_q] = !empty`; all other lanes are 0. On pop with `m_tlast = 1`, return to HEAD; otherwise stay in BODY.
- Single-flit packets (header with tlast) traverse HEAD → BODY → HEAD.
- `route_q` is stable for the entire packet regardless of later FIFO contents.
- `m_tready` on non-selected lanes is ignored.
- The block never drops or reorders flits. Backpressure holds `m_tdata`/`m_tlast`/`m_tvalid` stable until the handshake completes.
- Reset mid-packet: FIFO is flushed (pointers and count = 0), state = HEAD, `route_q` = 0. The partial packet is discarded; the downstream arbiter sees `m_tvalid` drop the cycle after `rst` is sampled.

## Timing
- Reset values: `s_tready` = 0 while `rst` is high and 1 the first cycle after; `m_tvalid` = 0; `m_tdata`/`m_tlast` = 0 (head of empty FIFO); state HEAD.
- Header latency: a flit accepted at edge t sits at the FIFO head in cycle t+1. HEAD latches the route at edge t+1, and `m_tvalid` asserts in cycle t+2.
- Body flits: 1 flit/cycle sustained in BODY with `m_tready` high and input streaming.
- Exactly one idle output cycle (the HEAD cycle) between consecutive packets.
- Full FIFO: `s_tready` deasserts in the cycle after the `FIFO_DEPTH`-th flit is accepted. It reasserts the cycle after the first pop.

## Test plan
- Routing matrix, X_COORD=1, Y_COORD=1, one single-flit packet each:
  - dest (2,1) → lane 2.
  - dest (0,1) → lane 4.
  - dest (1,2) → lane 1.
  - dest (1,0) → lane 3.
  - dest (1,1) → lane 0.
  - dest (2,0) → lane 2 (X first).
  - Each appears at cycle t+2; all other lanes stay 0.
- 4-flit packet to east, then 3-flit packet to west, back-to-back, `m_tready` all 1:
  - lane 2 valid for 4 consecutive cycles, then 1 idle cycle, then lane 4 valid for 3 cycles.
  - Data order matches input order.
- Backpressure: 8-flit packet with `m_tready[2]` = 0 for 10 cycles:
  - `s_tready` falls after 4 accepts.
  - `m_tdata` holds flit 0 stable.
  - After release, all 8 flits are delivered in order with no loss.
- Concurrent push/pop with FIFO count 2: count stays 2 and `s_tready` stays 1.
- Misdirected ready: `m_tready` = 5'b11011 while route = east: no pop occurs and `m_tvalid` = 5'b00100 is held.
- Reset mid-packet: assert `rst` after flit 2 of 5:
  - next cycle `m_tvalid` = 0 and `s_tready` = 0.
  - after release a new header routes correctly with no stale flits.

Source files
------------

// File: rtl/router_input_port_if.sv
// Stream bundle around one router ingress port: the upstream AXI-Stream link
// and the per-lane request lanes toward the output arbiters.
interface router_input_port_if #(
  parameter int DATA_W = 32,
  parameter int REN    = 5
);
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic [REN-1:0]    m_tvalid;
  logic [REN-1:0]    m_tready;

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tlast, m_tvalid
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tlast, m_tvalid
  );
endinterface

// File: rtl/router_input_port.sv
// Mesh router ingress: small flit FIFO plus XY route latch; the head flit is
// offered on exactly one output lane for the duration of its packet.
module router_input_port #(
  parameter int DATA_W     = 32,
  parameter int COORD_W    = 4,
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int REN        = 5
) (
  input logic               clk,
  input logic               rst,
  router_input_port_if.slave bus
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = $clog2(REN);

  typedef enum logic {HEAD, BODY} state_t;

  logic [DATA_W-1:0]     mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  route_load;
  logic [LANE_W-1:0]     route_q;
  logic [REN-1:0]        lane_vld;
  logic [DATA_W-1:0]     head_data;
  logic                  head_last;
  state_t                state_q;
  state_t                state_d;

  // X-first dimension-order routing; lane order local, north, east, south, west.
  function automatic logic [LANE_W-1:0] xy_route(input logic [2*COORD_W-1:0] hdr);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    dx = hdr[COORD_W-1:0];
    dy = hdr[2*COORD_W-1:COORD_W];
    if (dx > COORD_W'(X_COORD))      return LANE_W'(2);
    else if (dx < COORD_W'(X_COORD)) return LANE_W'(4);
    else if (dy > COORD_W'(Y_COORD)) return LANE_W'(1);
    else if (dy < COORD_W'(Y_COORD)) return LANE_W'(3);
    else                             return LANE_W'(0);
  endfunction

  assign full          = (count == CNT_W'(FIFO_DEPTH));
  assign empty         = (count == '0);
  assign bus.s_tready  = !full && !rst;
  assign push          = bus.s_tvalid && bus.s_tready;

  // The empty-FIFO head reads as zero so the storage array needs no reset.
  assign head_data     = empty ? '0 : mem[rd_ptr];
  assign head_last     = empty ? 1'b0 : last_mem[rd_ptr];
  assign bus.m_tdata   = head_data;
  assign bus.m_tlast   = head_last;
  assign bus.m_tvalid  = lane_vld;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]      <= bus.s_tdata;
      last_mem[wr_ptr] <= bus.s_tlast;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HEAD;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      if (route_load) route_q <= xy_route(head_data[2*COORD_W-1:0]);
    end
  end

  // HEAD spends one cycle latching the route; BODY streams until the tlast pop.
  always_comb begin
    state_d    = state_q;
    route_load = 1'b0;
    lane_vld   = '0;
    pop        = 1'b0;
    unique case (state_q)
      HEAD: begin
        if (!empty) begin
          route_load = 1'b1;
          state_d    = BODY;
        end
      end
      BODY: begin
        if (!empty) begin
          lane_vld[route_q] = 1'b1;
          pop               = bus.m_tready[route_q];
          if (pop && head_last) state_d = HEAD;
        end
      end
      default: state_d = HEAD;
    endcase
  end
endmodule

// File: tb/tb_router_input_port.sv
// Directed bench for router_input_port at mesh position (1,1): routing table,
// back-to-back packets, backpressure, concurrent push/pop and mid-packet reset.
module tb_router_input_port;
  localparam int DATA_W  = 32;
  localparam int COORD_W = 4;
  localparam int REN     = 5;
  localparam int DEPTH   = 4;

  typedef struct {
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [REN-1:0]     exp_vld;
  } route_vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  router_input_port_if #(.DATA_W(DATA_W), .REN(REN)) bus ();

  router_input_port #(
    .DATA_W(DATA_W), .COORD_W(COORD_W), .X_COORD(1), .Y_COORD(1),
    .FIFO_DEPTH(DEPTH), .REN(REN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tdata  = '0;
    bus.m_tready = '1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [3:0] dx, input logic [3:0] dy,
                                          input logic [7:0] tag);
    return {16'hC0DE, tag, dy, dx};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    route_vec_t        vecs [6];
    logic [DATA_W-1:0] f;
    logic [DATA_W-1:0] p2 [7];
    logic [DATA_W-1:0] p3 [8];
    logic [DATA_W-1:0] p4 [6];
    logic [REN-1:0]    exp_tr [12];
    logic [DATA_W-1:0] got [$];
    logic              accepted;
    int                sent;

    vecs[0] = '{4'd2, 4'd1, 5'b00100};
    vecs[1] = '{4'd0, 4'd1, 5'b10000};
    vecs[2] = '{4'd1, 4'd2, 5'b00010};
    vecs[3] = '{4'd1, 4'd0, 5'b01000};
    vecs[4] = '{4'd1, 4'd1, 5'b00001};
    vecs[5] = '{4'd2, 4'd0, 5'b00100};

    // Reset values
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.s_tdata  = '0;
    bus.m_tready = '1;
    rst = 1'b1;
    step();
    step();
    check("rst_s_tready", bus.s_tready, 0);
    check("rst_m_tvalid", bus.m_tvalid, 0);
    check("rst_m_tdata", bus.m_tdata, 0);
    check("rst_m_tlast", bus.m_tlast, 0);
    rst = 1'b0;
    step();
    check("post_rst_s_tready", bus.s_tready, 1);
    check("post_rst_m_tvalid", bus.m_tvalid, 0);

    // Routing table, one single-flit packet per destination
    for (int i = 0; i < 6; i++) begin
      f = mk(vecs[i].dx, vecs[i].dy, 8'(i));
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = f;
      bus.s_tlast  = 1'b1;
      step();
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
      check($sformatf("rt%0d_head_idle", i), bus.m_tvalid, 0);
      step();
      check($sformatf("rt%0d_lane", i), bus.m_tvalid, vecs[i].exp_vld);
      check($sformatf("rt%0d_data", i), bus.m_tdata, f);
      check($sformatf("rt%0d_last", i), bus.m_tlast, 1);
      step();
      check($sformatf("rt%0d_done", i), bus.m_tvalid, 0);
    end

    // Back-to-back 4-flit east then 3-flit west packets
    p2[0] = mk(4'd2, 4'd1, 8'h20);
    p2[1] = 32'hB0D0_0001;
    p2[2] = 32'hB0D0_0002;
    p2[3] = 32'hB0D0_0003;
    p2[4] = mk(4'd0, 4'd1, 8'h30);
    p2[5] = 32'hB0D0_0005;
    p2[6] = 32'hB0D0_0006;
    exp_tr = '{5'd0, 5'd4, 5'd4, 5'd4, 5'd4, 5'd0, 5'd16, 5'd16, 5'd16, 5'd0, 5'd0, 5'd0};
    got.delete();
    for (int k = 0; k < 12; k++) begin
      if (k < 7) begin
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = p2[k];
        bus.s_tlast  = (k == 3) || (k == 6);
        check($sformatf("b2b_s_tready%0d", k), bus.s_tready, 1);
      end else begin
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
      end
      if (|(bus.m_tvalid & bus.m_tready)) got.push_back(bus.m_tdata);
      step();
      check($sformatf("b2b_vld%0d", k), bus.m_tvalid, exp_tr[k]);
    end
    check("b2b_count", got.size(), 7);
    for (int j = 0; j < 7; j++)
      if (j < got.size()) check($sformatf("b2b_data%0d", j), got[j], p2[j]);

    // Backpressure on lane 2 with misdirected readies on the other lanes
    do_reset();
    for (int k = 0; k < 8; k++) p3[k] = (k == 0) ? mk(4'd2, 4'd1, 8'h40) : 32'hDA7A_0000 + k;
    got.delete();
    sent = 0;
    for (int k = 0; k < 30; k++) begin
      bus.m_tready = (k < 10) ? 5'b11011 : 5'b11111;
      if (sent < 8) begin
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = p3[sent];
        bus.s_tlast  = (sent == 7);
      end else begin
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
      end
      accepted = bus.s_tvalid && bus.s_tready;
      if (|(bus.m_tvalid & bus.m_tready)) got.push_back(bus.m_tdata);
      step();
      if (accepted) begin
        sent++;
        if (sent == 4) check("bp_full_after_4", bus.s_tready, 0);
      end
      if (k == 9) begin
        check("bp_hold_vld", bus.m_tvalid, 5'b00100);
        check("bp_hold_data", bus.m_tdata, p3[0]);
        check("bp_hold_ready", bus.s_tready, 0);
        check("bp_hold_sent", sent, 4);
      end
      if (k == 10) check("bp_reassert", bus.s_tready, 1);
    end
    check("bp_count", got.size(), 8);
    for (int j = 0; j < 8; j++)
      if (j < got.size()) check($sformatf("bp_data%0d", j), got[j], p3[j]);

    // Concurrent push and pop with two flits buffered
    do_reset();
    bus.m_tready = 5'b11011;
    for (int k = 0; k < 6; k++) p4[k] = (k == 0) ? mk(4'd2, 4'd1, 8'h50) : 32'h5EED_0000 + k;
    got.delete();
    for (int k = 0; k < 9; k++) begin
      if (k == 2) bus.m_tready = '1;
      if (k < 6) begin
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = p4[k];
        bus.s_tlast  = (k == 5);
        check($sformatf("pp_s_tready%0d", k), bus.s_tready, 1);
      end else begin
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
      end
      if (|(bus.m_tvalid & bus.m_tready)) got.push_back(bus.m_tdata);
      step();
      if (k >= 1 && k <= 6) begin
        check($sformatf("pp_vld%0d", k), bus.m_tvalid, 5'b00100);
        check($sformatf("pp_head%0d", k), bus.m_tdata, p4[k-1]);
      end
      if (k >= 7) check($sformatf("pp_idle%0d", k), bus.m_tvalid, 0);
    end
    check("pp_count", got.size(), 6);
    for (int j = 0; j < 6; j++)
      if (j < got.size()) check($sformatf("pp_data%0d", j), got[j], p4[j]);

    // Reset in the middle of a 5-flit north packet
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = (k == 0) ? mk(4'd1, 4'd2, 8'h60) : 32'hDEAD_0000 + k;
      bus.s_tlast  = 1'b0;
      step();
    end
    bus.s_tvalid = 1'b0;
    check("mr_pre_vld", bus.m_tvalid, 5'b00010);
    rst = 1'b1;
    step();
    check("mr_rst_vld", bus.m_tvalid, 0);
    check("mr_rst_ready", bus.s_tready, 0);
    check("mr_rst_data", bus.m_tdata, 0);
    rst = 1'b0;
    step();
    check("mr_post_ready", bus.s_tready, 1);
    check("mr_post_vld", bus.m_tvalid, 0);
    f = mk(4'd1, 4'd0, 8'h70);
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = f;
    bus.s_tlast  = 1'b1;
    step();
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    check("mr_new_head_idle", bus.m_tvalid, 0);
    step();
    check("mr_new_lane", bus.m_tvalid, 5'b01000);
    check("mr_new_data", bus.m_tdata, f);
    step();
    check("mr_new_done", bus.m_tvalid, 0);
    step();
    check("mr_no_stale", bus.m_tvalid, 0);
    check("mr_no_stale_data", bus.m_tdata, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
